pdm_playback: RTL and testbench
===============================

PDM_PLAYBACK -- requirements
Module: pdm_playback

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk_in  input  1  system clock, audio clock domain (98.3 MHz).
REQ-003 rst_in  input  1  synchronous reset, active-low.
REQ-004 enable_in  input  1  playback enable; low forces IDLE and flushes the buffer.
REQ-005 sample_in  input  8  signed two's-complement audio sample at the 12 kHz rate.
REQ-006 sample_valid_in  input  1  sample_in is valid this cycle.
REQ-007 sample_ready_out  output  1  the block accepts a sample this cycle.
REQ-008 pdm_step_in  input  1  single-cycle enable at the 3.072 MHz PDM bit rate.
REQ-009 pdm_out  output  1  registered first-order sigma-delta PDM bitstream to the speaker/amplifier.
REQ-010 playing_out  output  1  high while the state is PLAY.
REQ-011 underrun_out  output  1  single-cycle pulse when a frame boundary finds the buffer empty.
REQ-012 level_out  output  5  current buffer occupancy, 0..16.

Function
REQ-013 Buffer: 16-entry FIFO of 8-bit samples, with FIFO order preserved.
REQ-014 sample_ready_out SHALL equal (level < 16) and (state != IDLE); a push occurs when sample_valid_in and sample_ready_out are both high.
REQ-015 Push and pop in the same cycle: level is unchanged, and both operations take effect.
REQ-016 A push is never accepted when level == 16, even if a pop occurs that cycle.
REQ-017 Read and write pointers SHALL wrap modulo 16; level SHALL be a separate 5-bit count.
REQ-018 States: IDLE, PRIME, PLAY.
- IDLE -> PRIME when enable_in is high.
- PRIME -> PLAY when level >= 8.
- PLAY -> PRIME on underrun.
- Any state -> IDLE when enable_in is low; this has priority over all other transitions.
REQ-019 Entering IDLE: FIFO flushed (pointers and level = 0), cur_sample = 0, frame_cnt = 0.
REQ-020 PRIME -> PLAY cycle:
- pop the head into cur_sample;
- set frame_cnt = 0.
REQ-021 In PLAY, each pdm_step_in increments the 8-bit frame_cnt.
REQ-022 In PLAY, on pdm_step_in with frame_cnt == 255 (a frame boundary every 256 steps):
- if level > 0, pop into cur_sample;
- otherwise set cur_sample = 0, pulse underrun_out for one cycle, and go to PRIME.
REQ-023 Modulator: u = cur_sample with MSB inverted (offset binary, 0..255); 9-bit sum = acc[7:0] + u.
REQ-024 On every pdm_step_in, in any state, acc <= sum[7:0] and pdm_out <= sum[8].
REQ-025 pdm_out latency: registered one cycle after pdm_step_in. pdm_out is held between steps.
REQ-026 Density: sample s gives (s + 128)/256 ones per 256 steps.
- s = -128 gives all zeros.
- s = 0 gives a 1,0 alternation.
- s = 127 gives 255 ones per 256 steps.
REQ-027 IDLE and PRIME modulate cur_sample = 0, i.e. a midscale, silent bitstream.

Reset
REQ-028 When rst_in is low at a clk_in edge:
- state = IDLE; FIFO flushed; level = 0;
- cur_sample = 0, acc = 0, frame_cnt = 0;
- pdm_out = 0, underrun_out = 0, playing_out = 0, sample_ready_out = 0.
REQ-029 Reset mid-frame or mid-push SHALL discard all buffered samples; no partial state survives.

Structure
REQ-030 Shared package audio_pkg SHALL hold:
- the state enum;
- FIFO_DEPTH = 16, PRIME_LEVEL = 8, SAMPLES_PER_FRAME = 256.
REQ-031 The FIFO SHALL be the sub-module sample_fifo, with push/pop/level ports. The FSM, frame counter and modulator SHALL be in pdm_playback.

Verification
REQ-032 Reset: rst_in low for 3 cycles with traffic present -> all outputs are 0 and level_out = 0 the cycle after release.
REQ-033 Prime: enable = 1, push 8 samples of value 0.
- playing_out rises the cycle level reaches 8, and level_out drops to 7.
- Over the next 256 steps pdm_out alternates, giving 128 ones.
REQ-034 Density: stream 20 samples of 127, then 20 of -128, at one per 256 steps. Per frame, pdm_out gives:
- 255 ones for the 127 samples;
- 0 ones for the -128 samples.
REQ-035 Full/backpressure: push 20 samples back-to-back in PRIME with no steps.
- The first 16 are accepted, and sample_ready_out goes low at level 16.
- Values are popped later in push order.
REQ-036 Underrun: prime with 8 samples, then stop pushing.
- After the 8th frame boundary, underrun_out pulses exactly once.
- The state returns to PRIME and pdm_out returns to alternation.
REQ-037 Disable: drop enable_in mid-frame with level 5 -> next cycle level_out = 0, playing_out = 0, and pdm_out alternates.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and sizing for the PDM playback path: FSM states, FIFO depth,
// priming threshold, frame length and the signed-to-offset-binary helper.
package audio_pkg;

  localparam int FIFO_DEPTH        = 16;
  localparam int PRIME_LEVEL       = 8;
  localparam int SAMPLES_PER_FRAME = 256;

  localparam logic [4:0] LVL_FULL   = 5'(FIFO_DEPTH);
  localparam logic [4:0] LVL_PRIME  = 5'(PRIME_LEVEL);
  localparam logic [7:0] FRAME_LAST = 8'(SAMPLES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_e;

  // Two's-complement sample to offset binary: -128 -> 0, 0 -> 128, 127 -> 255.
  function automatic logic [7:0] to_offset(input logic [7:0] s);
    return {~s[7], s[6:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// 16-entry sample FIFO: zero-latency head on pop_dat_o, push refused when full
// and pop ignored when empty; flush and reset clear pointers and level.
module sample_fifo
  import audio_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] push_dat_i,
  input  logic       pop_i,
  output logic [7:0] pop_dat_o,
  output logic [4:0] level_o
);

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [3:0] wr_q, rd_q;
  logic [4:0] level_q;
  logic       do_push, do_pop;

  assign do_push   = push_i && (level_q < LVL_FULL);
  assign do_pop    = pop_i && (level_q != 5'd0);
  assign pop_dat_o = mem_q[rd_q];
  assign level_o   = level_q;

  // Storage is not reset; validity is tracked entirely by level_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_q    <= 4'd0;
      rd_q    <= 4'd0;
      level_q <= 5'd0;
    end else begin
      if (do_push) wr_q <= wr_q + 4'd1;
      if (do_pop)  rd_q <= rd_q + 4'd1;
      level_q <= level_q + {4'd0, do_push} - {4'd0, do_pop};
    end
  end

endmodule

// File: rtl/pdm_playback.sv
// Buffered 12 kHz sample playback as a first-order sigma-delta PDM stream; pdm_out
// follows each pdm_step_in by one cycle; sample_ready_out drops when full or idle.
module pdm_playback
  import audio_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic [7:0] sample_in,
  input  logic       sample_valid_in,
  output logic       sample_ready_out,
  input  logic       pdm_step_in,
  output logic       pdm_out,
  output logic       playing_out,
  output logic       underrun_out,
  output logic [4:0] level_out
);

  state_e     state_q;
  logic [7:0] cur_q, acc_q, frame_q;
  logic       pdm_q, und_q;
  logic [8:0] sum_d;
  logic [7:0] head_dat;
  logic [4:0] level;
  logic       fifo_push, fifo_pop, fifo_flush, frame_end;

  assign sample_ready_out = (level < LVL_FULL) && (state_q != ST_IDLE);
  assign fifo_push        = sample_valid_in && sample_ready_out;
  assign fifo_flush       = !enable_in;
  assign frame_end        = pdm_step_in && (frame_q == FRAME_LAST);
  assign sum_d            = {1'b0, acc_q} + {1'b0, to_offset(cur_q)};

  always_comb begin
    fifo_pop = 1'b0;
    if (enable_in) begin
      if (state_q == ST_PRIME && level >= LVL_PRIME)            fifo_pop = 1'b1;
      else if (state_q == ST_PLAY && frame_end && level != 5'd0) fifo_pop = 1'b1;
    end
  end

  sample_fifo u_fifo (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .flush_i    (fifo_flush),
    .push_i     (fifo_push),
    .push_dat_i (sample_in),
    .pop_i      (fifo_pop),
    .pop_dat_o  (head_dat),
    .level_o    (level)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      cur_q   <= 8'd0;
      acc_q   <= 8'd0;
      frame_q <= 8'd0;
      pdm_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      und_q <= 1'b0;
      // The modulator runs in every state; outside PLAY cur_q is zero (midscale).
      if (pdm_step_in) begin
        acc_q <= sum_d[7:0];
        pdm_q <= sum_d[8];
      end
      if (!enable_in) begin
        state_q <= ST_IDLE;
        cur_q   <= 8'd0;
        frame_q <= 8'd0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_PRIME;
          ST_PRIME: begin
            if (level >= LVL_PRIME) begin
              cur_q   <= head_dat;
              frame_q <= 8'd0;
              state_q <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (pdm_step_in) begin
              frame_q <= frame_q + 8'd1;
              if (frame_end) begin
                if (level != 5'd0) begin
                  cur_q <= head_dat;
                end else begin
                  cur_q   <= 8'd0;
                  und_q   <= 1'b1;
                  state_q <= ST_PRIME;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign pdm_out      = pdm_q;
  assign underrun_out = und_q;
  assign playing_out  = (state_q == ST_PLAY);
  assign level_out    = level;

endmodule

// File: tb/tb_pdm_playback.sv
// Directed bench for pdm_playback: a queue-based behavioural model checked every
// cycle, plus hand-computed frame densities and handshake expectations.
module tb_pdm_playback;

  logic       clk = 1'b0;
  logic       rst_n, en, valid, step;
  logic [7:0] smp;
  logic       ready, pdm, playing, und;
  logic [4:0] level;

  pdm_playback dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .enable_in        (en),
    .sample_in        (smp),
    .sample_valid_in  (valid),
    .sample_ready_out (ready),
    .pdm_step_in      (step),
    .pdm_out          (pdm),
    .playing_out      (playing),
    .underrun_out     (und),
    .level_out        (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int und_cnt = 0, step_mode = 0, cyc_cnt = 0;
  bit chk_en = 1'b0;
  logic rdy_s = 1'b0;
  logic [7:0] feed[$];
  int exp_v[20];

  // Behavioural model: 0 idle, 1 prime, 2 play
  int m_state = 0, m_cur = 0, m_fcnt = 0, m_acc = 0, m_pdm = 0, m_und = 0, m_ones = 0;
  int m_q[$];
  int frames[$];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int lvl, t;
    bit psh;
    if (!rst_n) begin
      m_state = 0; m_q.delete(); m_cur = 0; m_fcnt = 0;
      m_acc = 0; m_pdm = 0; m_und = 0;
      return;
    end
    lvl = m_q.size();
    psh = valid && (lvl < 16) && (m_state != 0);
    m_und = 0;
    if (step) begin
      t = m_acc + m_cur + 128;
      m_pdm = (t >= 256) ? 1 : 0;
      m_acc = t % 256;
      if (m_state == 2) m_ones += m_pdm;
    end
    if (!en) begin
      m_state = 0; m_q.delete(); m_cur = 0; m_fcnt = 0;
      return;
    end
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (lvl >= 8) begin
        m_cur = m_q.pop_front(); m_fcnt = 0; m_state = 2; m_ones = 0;
      end
    end else if (step) begin
      if (m_fcnt == 255) begin
        frames.push_back(m_ones);
        m_ones = 0;
        if (lvl > 0) m_cur = m_q.pop_front();
        else begin m_cur = 0; m_und = 1; m_state = 1; end
      end
      m_fcnt = (m_fcnt + 1) % 256;
    end
    if (psh) m_q.push_back(int'($signed(smp)));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    if (valid && rdy_s && feed.size() > 0) void'(feed.pop_front());
    #1;
    valid = (feed.size() > 0);
    smp   = (feed.size() > 0) ? feed[0] : 8'd0;
    step  = (step_mode == 1) ? 1'b1 : (step_mode == 2) ? cyc_cnt[0] : 1'b0;
    cyc_cnt++;
  endtask

  always @(negedge clk) begin
    rdy_s = ready;
    if (chk_en) begin
      und_cnt += int'(und);
      chk("cyc_ready",   int'(ready),   (m_q.size() < 16 && m_state != 0) ? 1 : 0);
      chk("cyc_level",   int'(level),   m_q.size());
      chk("cyc_playing", int'(playing), (m_state == 2) ? 1 : 0);
      chk("cyc_underrun", int'(und),    m_und);
      chk("cyc_pdm",     int'(pdm),     m_pdm);
    end
  end

  task automatic check_alt(string nm, int n);
    logic prev;
    for (int i = 0; i < n; i++) begin
      prev = pdm;
      cyc();
      chk(nm, int'(pdm), int'(!prev));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; valid = 1'b0; smp = 8'd0; step = 1'b0;
    repeat (2) cyc();
    chk_en = 1'b1;

    // Reset with buffered samples and live traffic
    rst_n = 1'b1; en = 1'b1; step_mode = 1;
    feed = '{8'd1, 8'd2, 8'd3, 8'd4};
    repeat (10) cyc();
    chk("pre_reset_level", int'(level), 4);
    feed = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1; en = 1'b0;
    cyc();
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_underrun", int'(und), 0);
    chk("rst_pdm", int'(pdm), 0);
    feed.delete();

    // Prime with 8 zeros, then let it run dry
    frames.delete(); und_cnt = 0; en = 1'b1;
    repeat (8) feed.push_back(8'd0);
    for (int i = 0; i < 40 && level != 5'd8; i++) cyc();
    chk("prime_level8", int'(level), 8);
    cyc();
    chk("prime_playing", int'(playing), 1);
    chk("prime_level7", int'(level), 7);
    for (int i = 0; i < 2400 && frames.size() < 8; i++) cyc();
    chk("prime_frames", frames.size(), 8);
    foreach (frames[k]) chk("frame_ones_zero", frames[k], 128);
    repeat (3) cyc();
    chk("underrun_once", und_cnt, 1);
    chk("underrun_playing", int'(playing), 0);
    check_alt("underrun_alt", 4);

    // Backpressure with no steps, then playback order
    step_mode = 0; frames.delete();
    for (int i = 0; i < 20; i++) begin
      exp_v[i] = i * 13 - 120;
      feed.push_back(8'(exp_v[i]));
    end
    repeat (25) cyc();
    chk("full_level", int'(level), 16);
    chk("full_ready", int'(ready), 0);
    repeat (5) cyc();
    chk("full_hold_level", int'(level), 16);
    step_mode = 1;
    for (int i = 0; i < 6000 && frames.size() < 20; i++) cyc();
    chk("order_frames", frames.size(), 20);
    foreach (frames[k]) if (k < 20) chk("order_ones", frames[k], exp_v[k] + 128);

    // Density extremes, stepping every other cycle
    frames.delete(); step_mode = 2;
    repeat (20) feed.push_back(8'd127);
    repeat (20) feed.push_back(8'h80);
    for (int i = 0; i < 22000 && frames.size() < 40; i++) cyc();
    chk("density_frames", frames.size(), 40);
    foreach (frames[k]) if (k < 40) chk("density_ones", frames[k], (k < 20) ? 255 : 0);

    // Disable mid-frame with 5 buffered
    frames.delete(); step_mode = 0;
    repeat (8) feed.push_back(8'd50);
    for (int i = 0; i < 40 && !playing; i++) cyc();
    chk("dis_playing", int'(playing), 1);
    step_mode = 1;
    for (int i = 0; i < 700 && frames.size() < 2; i++) cyc();
    chk("dis_frames", frames.size(), 2);
    repeat (100) cyc();
    chk("dis_level5", int'(level), 5);
    en = 1'b0;
    cyc();
    chk("dis_level0", int'(level), 0);
    chk("dis_playing0", int'(playing), 0);
    check_alt("dis_alt", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
